sci_reader: RTL and testbench
=============================

// Module: sci_reader
// PURPOSE
//  SCI read master for the VS1003 decoder: issues READ (0x03) + 4-bit address, shifts
//  16 data bits in on SO and returns them. Counterpart to the mp3 player's write-only
//  SCI/SDI path; used to poll SCI_DECODE_TIME so note scrolling follows playback.
//  Runs on the 2 MHz clock; the top level muxes XCS/SCK/SI to this block while bus_gnt=1.
// PARAMETERS
//  OPCODE_READ   8'h03     SCI read instruction byte
//  DREQ_TIMEOUT  16'hFFFF  max cycles waiting for DREQ high before aborting
// PORTS
//  clk       in   1   2 MHz system clock (clk2MHZ)
//  rst       in   1   synchronous, active-low reset
//  req       in   1   start read; sampled only in IDLE
//  addr      in   4   SCI register address, latched when req accepted
//  busy      out  1   high from req acceptance until cycle after done
//  done      out  1   one-cycle pulse: read finished (or aborted if err=1)
//  err       out  1   one-cycle pulse with done on DREQ timeout
//  rdata     out  16  last successfully read value; held between reads
//  bus_req   out  1   request SCI pins from arbiter
//  bus_gnt   in   1   arbiter grant; must stay high while bus_req=1
//  DREQ      in   1   VS1003 ready
//  SO        in   1   VS1003 serial out
//  XCS       out  1   SCI chip select, active low
//  SCK       out  1   serial clock
//  SI        out  1   serial data to VS1003, MSB first
// BEHAVIOUR
//  - Reset values: busy=0 done=0 err=0 rdata=0 bus_req=0 XCS=1 SCK=0 SI=0; state IDLE.
//    Reset mid-transfer: all outputs reach reset values on the next edge; no done.
//  - FSM: IDLE -> WAIT_GNT -> WAIT_DREQ -> SETUP -> SHIFT -> HOLD -> DONE -> IDLE.
//  - IDLE: req=1 latches {OPCODE_READ, 4'h0, addr, 16'h0} into a 32-bit shift reg;
//    busy=1, bus_req=1. req while busy is ignored; later addr changes are ignored.
//  - WAIT_GNT: hold until bus_gnt=1; no timeout. XCS stays 1.
//  - WAIT_DREQ: counter from 0; DREQ=1 -> SETUP. Counter reaching DREQ_TIMEOUT -> DONE
//    with err=1; XCS never asserted; rdata unchanged.
//  - SETUP (1 cycle, t=0): XCS=0, SCK=0, SI=bit31.
//  - SHIFT (64 cycles, t=1..64): bit i (0..31) uses two cycles: low phase SCK=0, SI=bit
//    31-i; high phase SCK=1, SI unchanged. For i>=16, SO is captured at the edge ending
//    the high phase (VS1003 drives SO after falling SCK). SI=0 during data bits.
//  - HOLD (t=65): SCK=0, XCS=0. DONE (t=66): XCS=1, rdata<=captured word, done=1,
//    bus_req=0. IDLE at t=67 with busy=0; earliest new acceptance at t=67.
//  - SCK never high while XCS=1; exactly 32 SCK rising edges per transaction.
//  - DREQ is checked only in WAIT_DREQ; its value during SHIFT is ignored.
// STRUCTURE
//  - Shared package vs1003_pkg: SCI opcodes (READ 8'h03, WRITE 8'h02), register
//    addresses (SCI_MODE 4'h0, SCI_STATUS 4'h1, SCI_DECODE_TIME 4'h4, SCI_HDAT0 4'h8),
//    FSM state encoding.
//  - One sub-module: sci_bit_sequencer (6-bit phase counter, SCK, bit index, capture
//    strobe); FSM, shift register and timeout counter stay in sci_reader.
// TESTING
//  1 req addr=4'h4, gnt/DREQ high, SO model returns 16'h00A5 -> SI bits 0x03,0x04,
//    0x0000; rdata=16'h00A5, done at t=66, 32 SCK rises, err=0.
//  2 DREQ low 10 cycles after grant -> XCS falls exactly 10 cycles later than case 1;
//    data correct.
//  3 DREQ_TIMEOUT=100, DREQ held 0 -> done&err on cycle 101 of WAIT_DREQ, XCS=1
//    throughout, rdata unchanged.
//  4 rst=0 during SHIFT bit 20 -> next edge XCS=1, SCK=0, busy=0, rdata=0; next req
//    completes normally.
//  5 second req and addr change to 4'h1 mid-transfer -> ignored; SI still sends 0x04;
//    one done only.
//  6 bus_gnt withheld 50 cycles -> bus_req=1, XCS=1, SCK=0 until grant; normal read.

Source files
------------

// File: rtl/vs1003_pkg.sv
// Shared VS1003 SCI definitions: instruction bytes, register addresses, reader FSM encoding.
package vs1003_pkg;

  localparam logic [7:0] SCI_OP_READ  = 8'h03;
  localparam logic [7:0] SCI_OP_WRITE = 8'h02;

  typedef logic [3:0] sci_addr_t;

  localparam sci_addr_t SCI_MODE        = 4'h0;
  localparam sci_addr_t SCI_STATUS      = 4'h1;
  localparam sci_addr_t SCI_DECODE_TIME = 4'h4;
  localparam sci_addr_t SCI_HDAT0       = 4'h8;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_GNT  = 3'd1;
  localparam logic [2:0] ST_WAIT_DREQ = 3'd2;
  localparam logic [2:0] ST_SETUP     = 3'd3;
  localparam logic [2:0] ST_SHIFT     = 3'd4;
  localparam logic [2:0] ST_HOLD      = 3'd5;
  localparam logic [2:0] ST_DONE      = 3'd6;

  // Read frame: opcode, zero nibble, address, then 16 don't-care bits sent as zero.
  function automatic logic [31:0] sci_read_frame(input logic [7:0] op, input sci_addr_t a);
    return {op, 4'h0, a, 16'h0000};
  endfunction

endpackage

// File: rtl/sci_bit_sequencer.sv
// Two-cycle-per-bit SCK generator for the 32-bit SCI frame; phase runs only while enabled.
module sci_bit_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  output logic       sck,
  output logic [4:0] bit_idx,
  output logic       capture
);

  logic [5:0] phase_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_reg <= '0;
    end else if (run) begin
      phase_reg <= phase_reg + 6'd1;
    end else begin
      phase_reg <= '0;
    end
  end

  // Even phase = SCK low, odd phase = SCK high; the edge ending a high phase samples SO.
  assign sck     = run & phase_reg[0];
  assign bit_idx = phase_reg[5:1];
  assign capture = sck & phase_reg[5];

endmodule

// File: rtl/sci_reader.sv
// VS1003 SCI read master: arbitrates for the pins, waits for DREQ, shifts a READ frame out
// and the 16-bit register value in on SO.
module sci_reader
  import vs1003_pkg::*;
#(
  parameter logic [7:0]  OPCODE_READ  = SCI_OP_READ,
  parameter logic [15:0] DREQ_TIMEOUT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [3:0]  addr,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] rdata,
  output logic        bus_req,
  input  logic        bus_gnt,
  input  logic        DREQ,
  input  logic        SO,
  output logic        XCS,
  output logic        SCK,
  output logic        SI
);

  logic [2:0]  state_reg, state_next;
  logic [31:0] shift_reg;
  logic [15:0] cnt_reg;
  logic [15:0] rdata_reg;
  logic        err_reg;
  logic        seq_sck, seq_capture, last_bit, dreq_expired;
  logic [4:0]  seq_bit_idx;

  sci_bit_sequencer u_seq (
    .clk     (clk),
    .rst     (rst),
    .run     (state_reg == ST_SHIFT),
    .sck     (seq_sck),
    .bit_idx (seq_bit_idx),
    .capture (seq_capture)
  );

  assign last_bit     = seq_sck && (seq_bit_idx == 5'd31);
  assign dreq_expired = (cnt_reg == DREQ_TIMEOUT - 16'd1);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:      if (req) state_next = ST_WAIT_GNT;
      ST_WAIT_GNT:  if (bus_gnt) state_next = ST_WAIT_DREQ;
      ST_WAIT_DREQ: begin
        if (DREQ)              state_next = ST_SETUP;
        else if (dreq_expired) state_next = ST_DONE;
      end
      ST_SETUP:     state_next = ST_SHIFT;
      ST_SHIFT:     if (last_bit) state_next = ST_HOLD;
      ST_HOLD:      state_next = ST_DONE;
      ST_DONE:      state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      shift_reg <= '0;
      cnt_reg   <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (req) begin
            shift_reg <= sci_read_frame(OPCODE_READ, addr);
            err_reg   <= 1'b0;
          end
        end
        ST_WAIT_GNT:  cnt_reg <= '0;
        ST_WAIT_DREQ: begin
          cnt_reg <= cnt_reg + 16'd1;
          if (!DREQ && dreq_expired) err_reg <= 1'b1;
        end
        // Outgoing bits leave from the top while SO samples enter at the bottom; only
        // samples from the data half are kept, so rdata ends up in shift_reg[15:0].
        ST_SHIFT: begin
          if (seq_sck) shift_reg <= {shift_reg[30:0], seq_capture & SO};
        end
        ST_DONE: begin
          if (!err_reg) rdata_reg <= shift_reg[15:0];
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state_reg != ST_IDLE);
  assign done    = (state_reg == ST_DONE);
  assign err     = done & err_reg;
  assign bus_req = busy & ~done;
  assign XCS     = ~((state_reg == ST_SETUP) || (state_reg == ST_SHIFT) || (state_reg == ST_HOLD));
  assign SCK     = seq_sck;
  assign SI      = ((state_reg == ST_SETUP) || (state_reg == ST_SHIFT)) & shift_reg[31];
  assign rdata   = rdata_reg;

endmodule

// File: tb/tb_sci_reader.sv
// Randomized bench for sci_reader: a VS1003 SO model plus cycle-level expectations
// derived from the transaction timeline (t=0 at chip select, done at t=66).
module tb_sci_reader;

  localparam logic [7:0] OP  = 8'h03;
  localparam int         TMO = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic [3:0]  addr = 4'h0;
  logic        bus_gnt = 1'b0;
  logic        DREQ = 1'b0;
  logic        SO = 1'b0;
  logic        busy, done, err, bus_req, XCS, SCK, SI;
  logic [15:0] rdata;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc = 0;
  int cur_gd = 0;
  int xcs_fall_c, done_c, done_cnt, rises, sck_bad, gnt_bad;
  logic [31:0] si_word, resp;
  logic        err_at_done, busy_at_done;
  logic        sck_prev = 1'b0;
  logic [15:0] model_rdata = 16'h0000;

  sci_reader #(.DREQ_TIMEOUT(16'd100)) dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .busy(busy), .done(done), .err(err),
    .rdata(rdata), .bus_req(bus_req), .bus_gnt(bus_gnt), .DREQ(DREQ), .SO(SO),
    .XCS(XCS), .SCK(SCK), .SI(SI)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor and SO responder; the VS1003 presents data bit (i-16) during the high phase of SCK bit i.
  always @(negedge clk) begin
    int c_now;
    c_now = cyc - acc + 1;
    if (!XCS && xcs_fall_c == 0) xcs_fall_c = c_now;
    if (SCK && XCS) sck_bad++;
    if (c_now <= cur_gd && (!bus_req || !XCS || SCK)) gnt_bad++;
    if (SCK && !sck_prev) begin
      si_word = {si_word[30:0], SI};
      SO = (rises >= 16 && rises < 32) ? resp[31 - rises] : 1'($urandom);
      rises++;
    end
    sck_prev = SCK;
    if (done) begin
      done_cnt++;
      done_c = c_now;
      err_at_done = err;
      busy_at_done = busy;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    xcs_fall_c = 0; done_c = 0; done_cnt = 0; rises = 0; sck_bad = 0; gnt_bad = 0;
    si_word = '0; err_at_done = 1'b0; busy_at_done = 1'b0;
  endtask

  task automatic run_txn(input logic [3:0] a, input logic [15:0] word, input int gd,
                         input int dd, input bit tmo, input bit extra);
    int exp_xcs, exp_done;
    @(negedge clk);
    req = 1'b1; addr = a; bus_gnt = (gd == 0); resp = {16'h0000, word};
    @(posedge clk); #1;
    acc = cyc; cur_gd = gd; clear_mon();
    exp_xcs  = tmo ? 0 : 3 + gd + dd;
    exp_done = tmo ? gd + 2 + TMO : 3 + gd + dd + 66;
    for (int c = 1; c <= exp_done + 3; c++) begin
      @(negedge clk);
      req = extra && (c == 30);
      if (extra && c == 30) addr = 4'h1;
      bus_gnt = (c > gd);
      if (c < gd + 2) DREQ = 1'($urandom);
      else if (tmo) DREQ = 1'b0;
      else if (c > gd + 2 + dd) DREQ = 1'($urandom);
      else DREQ = (c == gd + 2 + dd);
    end
    check("done_cnt", done_cnt, 1);
    check("done_cyc", done_c, exp_done);
    check("err", 32'(err_at_done), 32'(tmo));
    check("busy_at_done", 32'(busy_at_done), 1);
    check("busy_idle", 32'(busy), 0);
    check("xcs_fall", xcs_fall_c, exp_xcs);
    check("sck_rises", rises, tmo ? 0 : 32);
    check("sck_xcs_hi", sck_bad, 0);
    check("gnt_wait", gnt_bad, 0);
    if (!tmo) begin
      check("si_frame", si_word, {OP, 4'h0, a, 16'h0000});
      model_rdata = word;
    end
    check("rdata", 32'(rdata), 32'(model_rdata));
    $display("[TB] txn addr=%h gd=%0d dd=%0d tmo=%0d word=%h rdata=%h done_cyc=%0d",
             a, gd, dd, tmo, word, rdata, done_c);
  endtask

  task automatic reset_mid();
    @(negedge clk);
    req = 1'b1; addr = 4'h4; bus_gnt = 1'b1; DREQ = 1'b1; resp = {16'h0000, 16'hBEEF};
    @(posedge clk); #1;
    acc = cyc; cur_gd = 0; clear_mon();
    @(negedge clk);
    req = 1'b0;
    for (int k = 0; k < 200 && rises < 21; k++) @(negedge clk);
    check("rst_reach_bit20", 32'(rises >= 21), 1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_xcs", 32'(XCS), 1);
    check("rst_sck", 32'(SCK), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rdata", 32'(rdata), 0);
    check("rst_bus_req", 32'(bus_req), 0);
    check("rst_si", 32'(SI), 0);
    model_rdata = 16'h0000;
    @(negedge clk);
    rst = 1'b1;
    repeat (80) @(negedge clk);
    check("rst_no_done", done_cnt, 0);
    $display("[TB] txn reset during bit 20, rdata=%h", rdata);
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_err", 32'(err), 0);
    check("reset_rdata", 32'(rdata), 0);
    check("reset_bus_req", 32'(bus_req), 0);
    check("reset_xcs", 32'(XCS), 1);
    check("reset_sck", 32'(SCK), 0);
    check("reset_si", 32'(SI), 0);
    @(negedge clk);
    rst = 1'b1;
    clear_mon();

    run_txn(4'h4, 16'h00A5, 0, 0, 1'b0, 1'b0);
    run_txn(4'h4, 16'($urandom), 0, 10, 1'b0, 1'b0);
    run_txn(4'h8, 16'($urandom), 0, 0, 1'b1, 1'b0);
    run_txn(4'h4, 16'h1234, 0, 0, 1'b0, 1'b1);
    run_txn(4'h0, 16'($urandom), 50, 0, 1'b0, 1'b0);
    reset_mid();
    run_txn(4'h4, 16'h5A5A, 0, 0, 1'b0, 1'b0);
    for (int n = 0; n < 8; n++) begin
      run_txn(4'($urandom), 16'($urandom), int'($urandom_range(0, 4)),
              int'($urandom_range(0, 4)), ($urandom_range(0, 5) == 0), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
